// File: rtl/pc_npc_fetch_buffer_pkg.sv
// Shared types and defaults for the PC/nPC fetch buffer.
// Fetch FSM states, buffer entry layout and reset constants.
package pc_npc_fetch_buffer_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_PC_INC  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FULL
  } fetch_state_e;

  // Default-width view of one buffered fetch.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_npc_fetch_buffer_fifo.sv
// Synchronous FIFO with flush, used as the prefetch buffer.
// Head data reads as zero while empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i & ~flush_i & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  // Occupancy next state; flush wins over push/pop.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/pc_npc_fetch_buffer.sv
// IF stage with PC/nPC pair, imem req/ack and prefetch buffer.
// Optional perf counters: define FETCH_PERF_CNT_EN.
module pc_npc_fetch_buffer
  import pc_npc_fetch_buffer_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       INSTR_W   = DEF_INSTR_W,
  parameter int unsigned       BUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       PC_INC    = DEF_PC_INC,
  localparam int unsigned      CNT_W     = $clog2(BUF_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [CNT_W-1:0]   buf_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(PC_INC - 1);

  // Parameter-width counterpart of fetch_entry_t.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              accept, pop;
  entry_t            wr_e, rd_e;

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign id_valid  = (buf_count != '0);
  assign accept    = imem_req & imem_ack & ~redirect;
  assign pop       = id_valid & id_ready & ~redirect;

  assign wr_e.pc    = pc_q;
  assign wr_e.instr = imem_data;
  assign id_pc      = rd_e.pc;
  assign id_instr   = rd_e.instr;

  fetch_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (redirect),
    .push_i      (accept),
    .pop_i       (pop),
    .data_i      (wr_e),
    .data_o      (rd_e),
    .count_o     (buf_count),
    .count_next_o(cnt_d)
  );

  // PC/nPC next state: redirect reloads, accepted fetch advances.
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    unique case (1'b1)
      redirect: begin
        pc_d  = redirect_target & MASK;
        npc_d = (redirect_target & MASK) + INC;
      end
      accept: begin
        pc_d  = npc_q;
        npc_d = npc_q + INC;
      end
      default: ;
    endcase
  end

  // FSM next state from sampled fetch_en and next occupancy.
  always_comb begin
    if (!fetch_en)
      state_d = ST_IDLE;
    else if (cnt_d == CNT_W'(BUF_DEPTH))
      state_d = ST_FULL;
    else
      state_d = ST_FETCH;
  end

  // PC/nPC pair and fetch FSM registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + INC;
      state_q <= ST_IDLE;
    end else begin
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      state_q <= state_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (imem_req & ~imem_ack) | (state_q == ST_FULL);

  // Saturating fetch and stall counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && fetch_cnt_q != '1)
        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (stall && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
